rom_streamer: RTL and testbench



---
 rtl/rom_streamer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_rom_streamer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_streamer.sv
// rom_streamer: walks a contiguous ROM address window and streams the words out valid/ready.
// Latency: start edge -> first o_valid three cycles later; 1 word/cycle sustained with i_ready high.
// Backpressure: a 2-entry skid FIFO plus a read-credit rule; reads stall so nothing is ever dropped.
//
// Ports:
//   i_clk, i_rstn              clock (rising edge), asynchronous active-low reset
//   i_start, i_base, i_len     command; sampled only while IDLE
//   o_busy, o_done             busy in RUN/DRAIN; one-cycle done pulse at end of command
//   o_rom_addr, i_rom_data     ROM side (registered read, one-cycle latency)
//   o_data, o_valid, i_ready   downstream stream; o_last tags the final word
//   o_err                      range-error pulse, only when ROM_STREAM_ERR_EN is defined
//
// Build option: define ROM_STREAM_ERR_EN to reject commands whose window runs past ADDR_MAX.
// Without it, addresses wrap modulo 2^ADDR_WIDTH.

// Small synchronous FIFO with occupancy output, used as the stream skid buffer.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; the caller guarantees no push when full.
module rom_streamer_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers step with explicit wrap so DEPTH need not be a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (i_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (i_push) begin
                mem_q[wr_ptr_q] <= i_push_dat;
            end
        end
    end

    assign o_head_dat = mem_q[rd_ptr_q];
    assign o_count    = count_q;

endmodule

module rom_streamer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_MAX   = 1024,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last
`ifdef ROM_STREAM_ERR_EN
    ,
    output logic                  o_err
`endif
);

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    // ADDR_MAX describes the attached ROM; it can never exceed what the address bus reaches.
    if (ADDR_MAX > (1 << ADDR_WIDTH)) begin : g_addr_max_chk
        $error("rom_streamer: ADDR_MAX larger than the ROM address space");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  done_q;

    logic                  issue;
    logic                  pop;
    logic                  last_issue;
    logic                  range_err;
    logic                  cmd_seen;
    logic                  cmd_accept;
    logic                  cmd_null;
    logic                  last_pop;

    logic [CNT_W-1:0]      fifo_cnt;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  head_last;
    logic [CNT_W:0]        occupancy;
    logic                  credit_ok;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
`ifdef ROM_STREAM_ERR_EN
    // Window end computed one bit wider than the length so base+len cannot overflow.
    logic [LEN_WIDTH:0] end_addr;
    logic               err_q;

    assign end_addr  = (LEN_WIDTH + 1)'(i_base) + (LEN_WIDTH + 1)'(i_len);
    assign range_err = end_addr > (LEN_WIDTH + 1)'(ADDR_MAX);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cmd_seen & range_err;
        end
    end

    assign o_err = err_q;
`else
    assign range_err = 1'b0;
`endif

    assign cmd_seen   = (state_q == ST_IDLE) & i_start;
    assign cmd_accept = cmd_seen & (i_len != '0) & ~range_err;
    // Zero-length or rejected commands complete at once without touching the ROM.
    assign cmd_null   = cmd_seen & ((i_len == '0) | range_err);

    // ------------------------------------------------------------------
    // Read credit: a word is either buffered or in flight; together they
    // may not exceed the FIFO depth once this cycle's pop is counted.
    // ------------------------------------------------------------------
    assign pop        = o_valid & i_ready;
    assign occupancy  = {1'b0, fifo_cnt} + (CNT_W + 1)'(inflight_q);
    assign credit_ok  = occupancy < ((CNT_W + 1)'(FIFO_DEPTH) + (CNT_W + 1)'(pop));
    assign last_issue = (rem_q == LEN_WIDTH'(1));
    assign last_pop   = pop & head_last;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last-tagged word can only reach the head after the final issue.
                if (last_pop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy = 1'b0;
        issue  = 1'b0;
        case (state_q)
            ST_RUN: begin
                o_busy = 1'b1;
                issue  = credit_ok;
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
                issue  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address walker and read tracking. The ROM address is addr_q itself,
    // so it only moves on an issue (or when a new command loads it).
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            if (cmd_accept) begin
                addr_q <= i_base;
                rem_q  <= i_len;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                rem_q  <= rem_q - LEN_WIDTH'(1);
            end
            inflight_q      <= issue;
            inflight_last_q <= issue & last_issue;
            done_q          <= cmd_null | ((state_q == ST_DRAIN) & last_pop);
        end
    end

    assign o_rom_addr = addr_q;
    assign o_done     = done_q;

    // ------------------------------------------------------------------
    // Skid FIFO: ROM data is captured only in the cycle after an issue.
    // ------------------------------------------------------------------
    rom_streamer_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_push     (inflight_q),
        .i_push_dat ({inflight_last_q, i_rom_data}),
        .i_pop      (pop),
        .o_head_dat (fifo_head),
        .o_count    (fifo_cnt)
    );

    assign head_last = fifo_head[DATA_WIDTH];
    assign o_data    = fifo_head[DATA_WIDTH-1:0];
    assign o_valid   = (fifo_cnt != '0);
    assign o_last    = o_valid & head_last;

endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer: directed bench for rom_streamer with a registered-read ROM model.
// Latency: not applicable (testbench).
// Backpressure: driven from directed i_ready patterns.
module tb_rom_streamer;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = AW + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_start;
    logic [AW-1:0] i_base;
    logic [LW-1:0] i_len;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_last;
`ifdef ROM_STREAM_ERR_EN
    logic          o_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rom_streamer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ADDR_MAX   (1024),
        .LEN_WIDTH  (LW)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_start    (i_start),
        .i_base     (i_base),
        .i_len      (i_len),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (rom_data),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_last     (o_last)
`ifdef ROM_STREAM_ERR_EN
        ,
        .o_err      (o_err)
`endif
    );

    // ROM contents: tag in the top half, address in the low bits.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {16'hC0DE, 6'b0, a};
    endfunction

    // Registered-read ROM, one-cycle latency.
    always @(posedge clk) rom_data <= rom_word(o_rom_addr);

    // Advance to one time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; returns in cycle 1 of the command.
    task automatic start_cmd(input logic [AW-1:0] b, input logic [LW-1:0] l);
        i_base  = b;
        i_len   = l;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rstn    = 1'b0;
        i_start = 1'b0;
        i_base  = '0;
        i_len   = '0;
        i_ready = 1'b0;
        step();
        step();
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset o_busy: got %b expected 0", o_busy); end
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset o_done: got %b expected 0", o_done); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset o_valid: got %b expected 0", o_valid); end
        n_checks++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset o_last: got %b expected 0", o_last); end
        n_checks++; if (o_rom_addr !== 10'd0) begin n_fail++; $display("FAIL reset o_rom_addr: got %0d expected 0", o_rom_addr); end
`ifdef ROM_STREAM_ERR_EN
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset o_err: got %b expected 0", o_err); end
`endif
        rstn = 1'b1;
        step();
    endtask

    // base=5, len=4, ready high: words in cycles 3..6, done in cycle 7.
    task automatic test_basic();
        logic [AW-1:0] a;
        i_ready = 1'b1;
        start_cmd(10'd5, 11'd4);
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) begin
                n_checks++; if (o_rom_addr !== 10'd5) begin n_fail++; $display("FAIL basic first addr: got %0d expected 5", o_rom_addr); end
            end
            n_checks++;
            if (o_valid !== (c >= 3 && c <= 6)) begin
                n_fail++; $display("FAIL basic o_valid cycle %0d: got %b expected %b", c, o_valid, (c >= 3 && c <= 6));
            end
            if (c >= 3 && c <= 6) begin
                a = 10'(5 + c - 3);
                n_checks++; if (o_data !== rom_word(a)) begin n_fail++; $display("FAIL basic o_data cycle %0d: got %h expected %h", c, o_data, rom_word(a)); end
                n_checks++; if (o_last !== (c == 6)) begin n_fail++; $display("FAIL basic o_last cycle %0d: got %b expected %b", c, o_last, (c == 6)); end
            end
            n_checks++; if (o_done !== (c == 7)) begin n_fail++; $display("FAIL basic o_done cycle %0d: got %b expected %b", c, o_done, (c == 7)); end
            n_checks++; if (o_busy !== (c <= 6)) begin n_fail++; $display("FAIL basic o_busy cycle %0d: got %b expected %b", c, o_busy, (c <= 6)); end
            step();
        end
    endtask

    // base=0, len=8, i_ready pattern 1,0,0 repeating. The head word must equal
    // the next expected word every valid cycle, which covers stability in stalls.
    task automatic test_backpressure();
        int idx;
        int dones;
        idx   = 0;
        dones = 0;
        start_cmd(10'd0, 11'd8);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            i_ready = ((cyc % 3) == 1);
            if (o_valid) begin
                n_checks++;
                if (o_data !== rom_word(10'(idx))) begin
                    n_fail++; $display("FAIL bp o_data idx %0d: got %h expected %h", idx, o_data, rom_word(10'(idx)));
                end
                n_checks++;
                if (o_last !== (idx == 7)) begin
                    n_fail++; $display("FAIL bp o_last idx %0d: got %b expected %b", idx, o_last, (idx == 7));
                end
                if (i_ready) idx++;
            end
            if (o_done) begin
                dones++;
                break;
            end
            step();
        end
        n_checks++; if (idx != 8) begin n_fail++; $display("FAIL bp word count: got %0d expected 8", idx); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL bp done seen: got %0d expected 1", dones); end
        i_ready = 1'b1;
        step();
    endtask

    task automatic test_len0();
        i_ready = 1'b1;
        start_cmd(10'd3, 11'd0);
        n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL len0 o_done: got %b expected 1", o_done); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL len0 o_busy: got %b expected 0", o_busy); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL len0 o_valid: got %b expected 0", o_valid); end
        step();
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL len0 done width: got %b expected 0", o_done); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL len0 o_busy later: got %b expected 0", o_busy); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL len0 o_valid later: got %b expected 0", o_valid); end
    endtask

`ifndef ROM_STREAM_ERR_EN
    // base=1022, len=4: addresses 1022, 1023, 0, 1.
    task automatic test_wrap();
        logic [AW-1:0] exp_addr [4];
        exp_addr = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        i_ready = 1'b1;
        start_cmd(10'd1022, 11'd4);
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL wrap o_valid word %0d: got %b expected 1", k, o_valid); end
            n_checks++; if (o_data !== rom_word(exp_addr[k])) begin n_fail++; $display("FAIL wrap o_data word %0d: got %h expected %h", k, o_data, rom_word(exp_addr[k])); end
            n_checks++; if (o_last !== (k == 3)) begin n_fail++; $display("FAIL wrap o_last word %0d: got %b expected %b", k, o_last, (k == 3)); end
            step();
        end
        n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL wrap o_done: got %b expected 1", o_done); end
        step();
    endtask
`endif

    // A second command presented in the o_done cycle of the first.
    task automatic test_back_to_back();
        i_ready = 1'b1;
        start_cmd(10'd100, 11'd2);
        step();
        step();
        n_checks++; if (o_data !== rom_word(10'd100) || o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b A word0: got %h/%b expected %h/1", o_data, o_valid, rom_word(10'd100)); end
        step();
        n_checks++; if (o_data !== rom_word(10'd101) || o_last !== 1'b1) begin n_fail++; $display("FAIL b2b A word1: got %h/%b expected %h/1", o_data, o_last, rom_word(10'd101)); end
        step();
        n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL b2b A done: got %b expected 1", o_done); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b A busy at done: got %b expected 0", o_busy); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b valid at done: got %b expected 0", o_valid); end
        start_cmd(10'd200, 11'd1);
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b B busy: got %b expected 1", o_busy); end
        n_checks++; if (o_rom_addr !== 10'd200) begin n_fail++; $display("FAIL b2b B addr: got %0d expected 200", o_rom_addr); end
        step();
        step();
        n_checks++; if (o_valid !== 1'b1 || o_data !== rom_word(10'd200)) begin n_fail++; $display("FAIL b2b B word: got %h/%b expected %h/1", o_data, o_valid, rom_word(10'd200)); end
        n_checks++; if (o_last !== 1'b1) begin n_fail++; $display("FAIL b2b B last: got %b expected 1", o_last); end
        step();
        n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL b2b B done: got %b expected 1", o_done); end
        step();
    endtask

    // Reset in the middle of a stalled command, then a clean command.
    task automatic test_reset_mid();
        i_ready = 1'b0;
        start_cmd(10'd50, 11'd8);
        step();
        step();
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid buffered before reset: got %b expected 1", o_valid); end
        rstn = 1'b0;
        #1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid o_busy: got %b expected 0", o_busy); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid o_valid: got %b expected 0", o_valid); end
        n_checks++; if (o_last !== 1'b0) begin n_fail++; $display("FAIL rstmid o_last: got %b expected 0", o_last); end
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rstmid o_done: got %b expected 0", o_done); end
        n_checks++; if (o_rom_addr !== 10'd0) begin n_fail++; $display("FAIL rstmid o_rom_addr: got %0d expected 0", o_rom_addr); end
        step();
        rstn    = 1'b1;
        i_ready = 1'b1;
        step();
        start_cmd(10'd7, 11'd2);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid stale word cycle1: got %b expected 0", o_valid); end
        step();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid stale word cycle2: got %b expected 0", o_valid); end
        step();
        n_checks++; if (o_valid !== 1'b1 || o_data !== rom_word(10'd7)) begin n_fail++; $display("FAIL rstmid word0: got %h/%b expected %h/1", o_data, o_valid, rom_word(10'd7)); end
        step();
        n_checks++; if (o_data !== rom_word(10'd8) || o_last !== 1'b1) begin n_fail++; $display("FAIL rstmid word1: got %h/%b expected %h/1", o_data, o_last, rom_word(10'd8)); end
        step();
        n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL rstmid done: got %b expected 1", o_done); end
        step();
    endtask

`ifdef ROM_STREAM_ERR_EN
    task automatic test_range_err();
        i_ready = 1'b1;
        start_cmd(10'd1020, 11'd8);
        n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL err o_err: got %b expected 1", o_err); end
        n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL err o_done: got %b expected 1", o_done); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL err o_busy: got %b expected 0", o_busy); end
        for (int c = 2; c <= 4; c++) begin
            step();
            n_checks++; if (o_valid !== 1'b0 || o_err !== 1'b0) begin n_fail++; $display("FAIL err quiet cycle %0d: got %b/%b expected 0/0", c, o_valid, o_err); end
        end
        start_cmd(10'd1016, 11'd8);
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (o_valid !== 1'b1 || o_data !== rom_word(10'(1016 + k))) begin n_fail++; $display("FAIL err ok word %0d: got %h/%b expected %h/1", k, o_data, o_valid, rom_word(10'(1016 + k))); end
            step();
        end
        n_checks++; if (o_done !== 1'b1 || o_err !== 1'b0) begin n_fail++; $display("FAIL err ok done: got %b/%b expected 1/0", o_done, o_err); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len0();
`ifndef ROM_STREAM_ERR_EN
        test_wrap();
`endif
        test_back_to_back();
        test_reset_mid();
`ifdef ROM_STREAM_ERR_EN
        test_range_err();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
